// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FIFO count states for the ALU issue stage
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } fifo_cnt_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - command, ALU-side and result signals of the issue stage
interface alu_issue_stage_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_opcode;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_cin;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_opcode;
  logic         alu_cin;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;
  logic [W-1:0] acc;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_use_acc,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_cin,
    input  alu_result, alu_cout,
    output res_valid, res_data, res_flags, acc,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_use_acc,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_cin,
    output alu_result, alu_cout,
    input  res_valid, res_data, res_flags, acc,
    output res_ready
  );
endinterface

// File: rtl/alu_res_fifo.sv
// rtl/alu_res_fifo.sv - two-entry in-order result FIFO; entry 0 is always the head
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [P-1:0] push_data_i,
  input  logic         pop_i,
  output fifo_cnt_e    count_o,
  output logic [P-1:0] head_o
);

  fifo_cnt_e    cnt_q;
  logic [P-1:0] e0_q;
  logic [P-1:0] e1_q;
  logic         pop;
  logic         push;

  assign pop     = pop_i && (cnt_q != CNT_EMPTY);
  assign push    = push_i && ((cnt_q != CNT_FULL) || pop);
  assign count_o = cnt_q;
  assign head_o  = e0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_EMPTY;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      unique case (cnt_q)
        CNT_EMPTY: if (push) begin
          e0_q  <= push_data_i;
          cnt_q <= CNT_ONE;
        end
        CNT_ONE: begin
          if (push && pop) begin
            e0_q <= push_data_i;
          end else if (push) begin
            e1_q  <= push_data_i;
            cnt_q <= CNT_FULL;
          end else if (pop) begin
            cnt_q <= CNT_EMPTY;
          end
        end
        CNT_FULL: if (pop) begin
          // shift the second entry into the head slot
          e0_q <= e1_q;
          if (push) e1_q <= push_data_i;
          else      cnt_q <= CNT_ONE;
        end
        default: cnt_q <= CNT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registers ALU operands, derives flags from the ALU outputs
// and buffers results with backpressure; accumulator forwarded from the in-flight op.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);

  logic         iss_valid_q, iss_valid_d;
  logic [W-1:0] iss_a_q, iss_a_d;
  logic [W-1:0] iss_b_q, iss_b_d;
  logic [1:0]   iss_op_q, iss_op_d;
  logic         iss_cin_q, iss_cin_d;
  logic [W-1:0] acc_q, acc_d;

  fifo_cnt_e    fifo_cnt;
  logic [W+3:0] fifo_head;
  logic [3:0]   flags;
  logic         pop, iss_move, accept;

  assign pop           = bus.res_valid && bus.res_ready;
  assign iss_move      = iss_valid_q && ((fifo_cnt != CNT_FULL) || pop);
  assign bus.cmd_ready = !iss_valid_q || iss_move;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.alu_a      = iss_a_q;
  assign bus.alu_b      = iss_b_q;
  assign bus.alu_opcode = iss_op_q;
  assign bus.alu_cin    = iss_cin_q;
  assign bus.acc        = acc_q;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_op_d    = iss_op_q;
    iss_cin_d   = iss_cin_q;
    acc_d       = iss_move ? bus.alu_result : acc_q;
    if (accept) begin
      iss_valid_d = 1'b1;
      // a dependent command accepted alongside a move must see the fresh result
      iss_a_d     = bus.cmd_use_acc ? acc_d : bus.cmd_a;
      iss_b_d     = bus.cmd_b;
      iss_op_d    = bus.cmd_opcode;
      iss_cin_d   = (bus.cmd_opcode == OP_ADD) ? bus.cmd_cin : 1'b0;
    end else if (iss_move) begin
      iss_valid_d = 1'b0;
    end
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (bus.alu_result == '0);
    flags[FLAG_N] = bus.alu_result[W-1];
    unique case (iss_op_q)
      OP_ADD: begin
        flags[FLAG_C] = bus.alu_cout;
        flags[FLAG_V] = (iss_a_q[W-1] == iss_b_q[W-1]) && (bus.alu_result[W-1] != iss_a_q[W-1]);
      end
      OP_SUB: begin
        flags[FLAG_C] = bus.alu_cout;
        flags[FLAG_V] = (iss_a_q[W-1] != iss_b_q[W-1]) && (bus.alu_result[W-1] != iss_a_q[W-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_op_q    <= '0;
      iss_cin_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_op_q    <= iss_op_d;
      iss_cin_q   <= iss_cin_d;
      acc_q       <= acc_d;
    end
  end

  alu_res_fifo #(.P(W + 4)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (iss_move),
    .push_data_i ({flags, bus.alu_result}),
    .pop_i       (pop),
    .count_o     (fifo_cnt),
    .head_o      (fifo_head)
  );

  assign bus.res_valid = (fifo_cnt != CNT_EMPTY);
  assign bus.res_data  = fifo_head[W-1:0];
  assign bus.res_flags = fifo_head[W+3:W];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  alu_issue_stage_if #(.W(W)) bus();

  alu_issue_stage #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stand-in for the neighbouring alu_4bit
  always_comb begin
    bus.alu_cout   = 1'b0;
    bus.alu_result = '0;
    case (bus.alu_opcode)
      OP_ADD:  {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
      OP_SUB:  {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
  end

  typedef struct {
    int data;
    int flags;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   m_acc = 0;

  // returns {V,C,N,Z,result} from plain integer arithmetic
  function automatic logic [7:0] ref_op(input logic [1:0] op, input int a, input int b, input int cin);
    int sa, sb, s, r;
    logic c, v;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        r = (a + b + cin) % 16;
        c = (a + b + cin) > 15;
        s = sa + sb + cin;
        v = (s > 7) || (s < -8);
      end
      OP_SUB: begin
        r = (a - b + 16) % 16;
        c = (a >= b);
        s = sa - sb;
        v = (s > 7) || (s < -8);
      end
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return {v, c, (r >= 8), (r == 0), 4'(r)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic       pop, exp_valid;
    logic [7:0] e;
    int         a_eff;
    if (!rst_n) begin
      q.delete();
      m_acc = 0;
    end else begin
      pop = bus.res_valid && bus.res_ready;
      exp_valid = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      chk("res_valid", int'(bus.res_valid), int'(exp_valid));
      if (bus.res_valid && q.size() > 0) begin
        chk("res_data", int'(bus.res_data), q[0].data);
        chk("res_flags", int'(bus.res_flags), q[0].flags);
      end
      chk("cmd_ready", int'(bus.cmd_ready), int'((q.size() < 3) || pop));
      if (pop && q.size() > 0) void'(q.pop_front());
      if (bus.cmd_valid && bus.cmd_ready) begin
        a_eff = bus.cmd_use_acc ? m_acc : int'(bus.cmd_a);
        e = ref_op(bus.cmd_opcode, a_eff, int'(bus.cmd_b), int'(bus.cmd_cin));
        m_acc = int'(e[3:0]);
        q.push_back('{data: int'(e[3:0]), flags: int'(e[7:4]), cyc: cyc});
      end
    end
    cyc++;
  end

  task automatic send(input logic [1:0] op, input int a, input int b, input logic cin, input logic ua);
    logic ok;
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = op;
    bus.cmd_a       = 4'(a);
    bus.cmd_b       = 4'(b);
    bus.cmd_cin     = cin;
    bus.cmd_use_acc = ua;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_cin     = 1'b0;
    bus.cmd_use_acc = 1'b0;
    bus.res_ready   = 1'b1;
    idle(3);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_alu_a", int'(bus.alu_a), 0);
    chk("rst_alu_b", int'(bus.alu_b), 0);
    chk("rst_alu_op", int'(bus.alu_opcode), 0);
    chk("rst_alu_cin", int'(bus.alu_cin), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_res_flags", int'(bus.res_flags), 0);
    chk("rst_acc", int'(bus.acc), 0);
    rst_n = 1'b1;

    chk("model_add", int'(ref_op(OP_ADD, 3, 4, 0)), 8'h07);
    chk("model_ovf", int'(ref_op(OP_ADD, 7, 1, 0)), 8'hA8);
    chk("model_and", int'(ref_op(OP_AND, 10, 6, 1)), 8'h02);
    chk("model_or", int'(ref_op(OP_OR, 10, 6, 1)), 8'h2E);
    chk("model_sub", int'(ref_op(OP_SUB, 8, 1, 1)), 8'hC7);

    idle(2);
    send(OP_ADD, 3, 4, 1'b0, 1'b0);
    idle(1);
    chk("add_res_valid", int'(bus.res_valid), 1);
    chk("add_data", int'(bus.res_data), 7);
    chk("add_flags", int'(bus.res_flags), 0);
    chk("add_acc", int'(bus.acc), 7);

    send(OP_ADD, 7, 1, 1'b0, 1'b0);
    idle(1);
    chk("ovf_data", int'(bus.res_data), 8);
    chk("ovf_flags", int'(bus.res_flags), 4'b1010);

    idle(3);
    bus.res_ready = 1'b0;
    send(OP_ADD, 1, 1, 1'b0, 1'b0);
    send(OP_ADD, 2, 2, 1'b0, 1'b0);
    send(OP_ADD, 3, 3, 1'b0, 1'b0);
    chk("bp_ready_low", int'(bus.cmd_ready), 0);
    idle(2);
    chk("bp_ready_held", int'(bus.cmd_ready), 0);
    chk("bp_alu_stable", int'(bus.alu_a), 3);
    bus.res_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", int'(bus.cmd_ready), 1);
    chk("bp_head_first", int'(bus.res_data), 2);
    idle(5);

    start = edges;
    send(OP_ADD, 5, 0, 1'b0, 1'b0);
    send(OP_ADD, 0, 2, 1'b0, 1'b1);
    send(OP_ADD, 0, 1, 1'b0, 1'b1);
    chk("fwd_no_stall", edges - start, 3);
    idle(1);
    chk("fwd_acc", int'(bus.acc), 8);
    chk("fwd_last", int'(bus.res_data), 8);
    idle(3);

    send(OP_AND, 10, 6, 1'b1, 1'b0);
    send(OP_OR, 10, 6, 1'b1, 1'b0);
    chk("and_data", int'(bus.res_data), 4'b0010);
    chk("and_flags", int'(bus.res_flags), 0);
    idle(1);
    chk("or_data", int'(bus.res_data), 4'b1110);
    chk("or_flags", int'(bus.res_flags), 4'b0010);
    idle(3);

    bus.res_ready = 1'b0;
    send(OP_ADD, 1, 2, 1'b0, 1'b0);
    send(OP_SUB, 9, 3, 1'b0, 1'b0);
    send(OP_OR, 4, 1, 1'b0, 1'b0);
    chk("rst_full_ready", int'(bus.cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.res_valid), 0);
    chk("mid_rst_ready", int'(bus.cmd_ready), 1);
    chk("mid_rst_acc", int'(bus.acc), 0);
    idle(1);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("post_rst_no_stale", int'(bus.res_valid), 0);
    end

    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid   = 1'($urandom_range(0, 1));
      bus.cmd_opcode  = 2'($urandom_range(0, 3));
      bus.cmd_a       = 4'($urandom_range(0, 15));
      bus.cmd_b       = 4'($urandom_range(0, 15));
      bus.cmd_cin     = 1'($urandom_range(0, 1));
      bus.cmd_use_acc = 1'($urandom_range(0, 1));
      bus.res_ready   = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    idle(10);
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipelined issue/retire wrapper around the `alu_4bit` datapath. It sits directly upstream and downstream of that instance. It accepts operation commands over a valid/ready handshake and registers the operands it drives into the ALU. One cycle later it captures the ALU result and carry, derives Z/N/C/V flags, and buffers up to two results for a consumer with backpressure. An internal accumulator allows chained operations, with forwarding from the in-flight operation.

## Interface
- `W`, 4: datapath width; must match the ALU instance.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_opcode`  in  2  00 add, 01 sub, 10 and, 11 or.
- `cmd_a`, `cmd_b`  in  W  operands.
- `cmd_cin`  in  1  carry-in; used for add only.
- `cmd_use_acc`  in  1  1: operand A is taken from the accumulator instead of `cmd_a`.
- `alu_a`, `alu_b`  out  W  registered operands to the ALU.
- `alu_opcode`  out  2  registered opcode to the ALU.
- `alu_cin`  out  1  registered carry-in to the ALU.
- `alu_result`  in  W  ALU result, combinational from `alu_*`.
- `alu_cout`  in  1  ALU carry-out.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts; a pop occurs on `res_valid && res_ready`.
- `res_data`  out  W  result.
- `res_flags`  out  4  {V, C, N, Z}.
- `acc`  out  W  current accumulator value.

## Operation
- **Issue register.** Holds `iss_valid`, A, B, opcode, and cin; its outputs drive `alu_*` directly.
  - `alu_cin` equals the command's `cmd_cin` for opcode 00 and is forced to 0 for all other opcodes.
- **Issue move.** `iss_move = iss_valid && (fifo_count < 2 || pop)`. On `iss_move`, the result and flags are written into the FIFO.
- **Command ready.** `cmd_ready = !iss_valid || iss_move`.
- **Accumulator.** Updated to `alu_result` on every `iss_move`.
- **Accumulator forwarding.** When a command with `cmd_use_acc = 1` is accepted in the same cycle as `iss_move`, operand A is `alu_result`, not the stale `acc` register.
- **Flags**, computed from the issue-register operands and the ALU outputs:
  - Z = (result == 0).
  - N = result[W-1].
  - C = `alu_cout` for add/sub, 0 for and/or.
  - V for add: a[W-1] == b[W-1] and result[W-1] != a[W-1].
  - V for sub: a[W-1] != b[W-1] and result[W-1] != a[W-1].
  - V is 0 for and/or.
- **Result FIFO.**
  - Two entries, in-order.
  - Count states EMPTY(0), ONE(1), FULL(2).
  - Transitions: push only → +1; pop only → −1; push and pop together → count unchanged.
  - At FULL, a push is allowed only when a pop occurs in the same cycle.
  - `res_*` always present the head entry.
- **Reset.** `rst_n` low clears `iss_valid`, `fifo_count`, `acc`, and all data registers to 0. Resulting output values:
  - `res_valid = 0`, `cmd_ready = 1`.
  - `alu_* = 0`, `res_data = 0`, `res_flags = 0`, `acc = 0`.
- **Reset mid-operation.** Asserting reset while operations are in flight discards them; no partial result is emitted after release.

## Timing
- Command accepted at edge T → issue register loaded at T → ALU evaluates during cycle T..T+1 → FIFO write at edge T+1 → `res_valid` high after T+1.
  - Minimum latency is 2 edges from acceptance to a result being visible.
- Throughput is one operation per cycle while `res_ready = 1`.
- **`res_ready` held low:**
  - Two results fill the FIFO.
  - A third operation remains in the issue register.
  - `cmd_ready` goes low with the FIFO full and the issue register occupied, and stays low until a pop.
- **Back-to-back dependent commands** (`cmd_use_acc = 1` every cycle) run at full rate, using the forwarding path.
- `cmd_*` are sampled only on acceptance. The `alu_*` outputs stay stable while the issue register is stalled.

## Structure
- **Package `alu_pkg`:**
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`;
  - flag bit indices `FLAG_Z = 0`, `FLAG_N = 1`, `FLAG_C = 2`, `FLAG_V = 3`;
  - FIFO depth constant 2.
- **Sub-module `alu_res_fifo`:** 2-entry FIFO with a (W+4)-bit payload and push/pop/count interface. Flag logic and the accumulator stay in the top level.
- The ALU is instantiated beside this block, not inside it.

## Test plan
- Reset, then add 3 + 4 with cin = 0 → 2 edges after acceptance: `res_data` = 7, flags = 0000, `acc` = 7.
- Add 7 + 1 with cin = 0 (W = 4) → `res_data` = 8, flags V = 1, N = 1, C = 0, Z = 0.
- Hold `res_ready = 0` and issue 3 commands back-to-back → `cmd_ready` drops after the 3rd command. Release `res_ready` → results pop in issue order, `cmd_ready` returns 1 on the first pop.
- Load 5 (add 5 + 0), then in the next cycle issue add with `cmd_use_acc = 1`, `cmd_b = 2`, then again with `cmd_b = 1` → results 5, 7, 8 with no stall (forwarding exercised).
- Issue and/or with patterns 1010/0110 → results 0010 and 1110, C = 0 and V = 0 on both.
- Assert `rst_n` low with the FIFO full and the issue register occupied → immediately `res_valid` = 0, `cmd_ready` = 1, `acc` = 0; no stale results appear after release.
